// File: rtl/peripheral_mpi_wb_pkg.sv
// Shared definitions for the MPI/UART register-bus Wishbone initiator.
//   wb_state_t     : initiator FSM states
//   WB_SEL_BYTE0   : byte select driven during every cycle (8-bit slave on lane 0)
//   WB_AW_DEFAULT  : default register address width
//   WB_DW_DEFAULT  : default register data width
package peripheral_mpi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [3:0] WB_SEL_BYTE0  = 4'b0001;
    localparam int         WB_AW_DEFAULT = 3;
    localparam int         WB_DW_DEFAULT = 8;

endpackage

// File: rtl/peripheral_mpi_wb_if.sv
// Wishbone classic bus bundle between the initiator and the register slave.
//   wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o/wb_stb_o/wb_cyc_o : initiator -> slave
//   wb_dat_i/wb_ack_i                                     : slave -> initiator
// Modports: master (initiator side), slave (peripheral side).
interface peripheral_mpi_wb_if
    import peripheral_mpi_wb_pkg::*;
#(
    parameter int AW = WB_AW_DEFAULT,
    parameter int DW = WB_DW_DEFAULT
);
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/peripheral_mpi_wb_timeout.sv
// Bus-cycle watchdog: counts cycles spent waiting for an acknowledge.
//   clk    : clock
//   srst   : synchronous active-high reset
//   clr    : clear counter to zero (held while the initiator is idle)
//   en     : count one more waiting cycle
//   expire : counter has reached TIMEOUT-1, i.e. the current cycle is the last one allowed
module peripheral_mpi_wb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count_reg;

    // Saturates at the expire value so the counter can never wrap.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_reg <= '0;
        end else if (en && !expire) begin
            count_reg <= count_reg + TW'(1);
        end
    end

    assign expire = (count_reg == TW'(TIMEOUT - 1));
endmodule

// File: rtl/peripheral_mpi_wb_initiator.sv
// Wishbone classic-cycle master for the 8-bit MPI/UART register slave.
// One register read/write command per WB cycle, with a timeout abort.
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake; cmd_we/cmd_adr/cmd_dat payload
//   rsp_valid/rsp_ready       : response handshake; rsp_dat/rsp_err payload
//   busy_o                    : a command is in flight (state != IDLE)
//   wb                        : Wishbone bus, master modport
module peripheral_mpi_wb_initiator
    import peripheral_mpi_wb_pkg::*;
#(
    parameter int AW      = WB_AW_DEFAULT,
    parameter int DW      = WB_DW_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_dat,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dat,
    output logic          rsp_err,
    output logic          busy_o,
    peripheral_mpi_wb_if.master wb
);
    wb_state_t     state_reg, state_next;
    logic [AW-1:0] adr_reg, adr_next;
    logic [DW-1:0] dat_reg, dat_next;
    logic          we_reg, we_next;
    logic [3:0]    sel_reg, sel_next;
    logic          strobe_reg, strobe_next;  // drives both cyc and stb
    logic          rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0] rsp_dat_reg, rsp_dat_next;
    logic          rsp_err_reg, rsp_err_next;

    logic tmr_clr, tmr_en, tmr_expire;

    peripheral_mpi_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (wb_clk_i),
        .srst   (wb_rst_i),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_next     = state_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        we_next        = we_reg;
        sel_next       = sel_reg;
        strobe_next    = strobe_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
        rsp_err_next   = rsp_err_reg;
        tmr_clr        = 1'b0;
        tmr_en         = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Timer is held clear so every BUS entry starts from zero.
                tmr_clr = 1'b1;
                if (cmd_valid) begin
                    adr_next    = cmd_adr;
                    dat_next    = cmd_dat;
                    we_next     = cmd_we;
                    sel_next    = WB_SEL_BYTE0;
                    strobe_next = 1'b1;
                    state_next  = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so an ack on the final allowed cycle completes normally.
                if (wb.wb_ack_i) begin
                    rsp_dat_next   = we_reg ? '0 : wb.wb_dat_i;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    strobe_next    = 1'b0;
                    sel_next       = '0;
                    we_next        = 1'b0;
                    state_next     = RESP;
                end else if (tmr_expire) begin
                    rsp_dat_next   = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    strobe_next    = 1'b0;
                    sel_next       = '0;
                    we_next        = 1'b0;
                    state_next     = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= IDLE;
            adr_reg       <= '0;
            dat_reg       <= '0;
            we_reg        <= 1'b0;
            sel_reg       <= '0;
            strobe_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            we_reg        <= we_next;
            sel_reg       <= sel_next;
            strobe_reg    <= strobe_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign busy_o      = (state_reg != IDLE);
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_dat     = rsp_dat_reg;
    assign rsp_err     = rsp_err_reg;
    assign wb.wb_adr_o = adr_reg;
    assign wb.wb_dat_o = dat_reg;
    assign wb.wb_we_o  = we_reg;
    assign wb.wb_sel_o = sel_reg;
    assign wb.wb_stb_o = strobe_reg;
    assign wb.wb_cyc_o = strobe_reg;
endmodule

// File: tb/tb_peripheral_mpi_wb_initiator.sv
// Directed bench for peripheral_mpi_wb_initiator with a small ack-delay slave.
module tb_peripheral_mpi_wb_initiator;
    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [2:0] cmd_adr = '0;
    logic [7:0] cmd_dat = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_dat;
    logic       rsp_err;
    logic       busy_o;

    // slave behaviour knobs
    logic       ack_en = 1'b0;
    logic       force_ack = 1'b0;
    int         ack_wait = 0;
    int         stb_cnt = 0;
    logic [7:0] slave_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_cycles;
    int hold_bad;
    bit rsp_seen;

    always #5 clk = ~clk;

    peripheral_mpi_wb_if #(.AW(3), .DW(8)) wb_bus ();

    peripheral_mpi_wb_initiator #(.AW(3), .DW(8), .TIMEOUT(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .busy_o    (busy_o),
        .wb        (wb_bus)
    );

    // Slave acks after ack_wait wait states of stb being high.
    assign wb_bus.wb_ack_i = force_ack | (ack_en & wb_bus.wb_stb_o & (stb_cnt == ack_wait));
    assign wb_bus.wb_dat_i = slave_rdata;

    always @(posedge clk) begin
        if (wb_rst_i)                                stb_cnt <= 0;
        else if (wb_bus.wb_stb_o && !wb_bus.wb_ack_i) stb_cnt <= stb_cnt + 1;
        else                                         stb_cnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        step();
        cmd_valid = 1'b0;
    endtask

    // Issue one command and follow the bus until rsp_valid (bounded).
    task automatic run_txn(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        issue(we, adr, dat);
        stb_cycles = 0;
        hold_bad   = 0;
        rsp_seen   = 0;
        for (int i = 0; i < 40; i++) begin
            if (wb_bus.wb_stb_o) begin
                stb_cycles++;
                if (wb_bus.wb_cyc_o !== 1'b1 || wb_bus.wb_adr_o !== adr ||
                    wb_bus.wb_we_o !== we || wb_bus.wb_sel_o !== 4'b0001 ||
                    (we && wb_bus.wb_dat_o !== dat))
                    hold_bad++;
            end
            if (rsp_valid) begin
                rsp_seen = 1;
                break;
            end
            step();
        end
        check_eq("rsp_seen", 32'(rsp_seen), 32'd1);
        $display("txn we=%0d adr=%0d dat=%02h stb_cycles=%0d rsp_dat=%02h rsp_err=%0d",
                 we, adr, dat, stb_cycles, rsp_dat, rsp_err);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cyc",   32'(wb_bus.wb_cyc_o), 32'd0);
        check_eq("rst_stb",   32'(wb_bus.wb_stb_o), 32'd0);
        check_eq("rst_we",    32'(wb_bus.wb_we_o),  32'd0);
        check_eq("rst_sel",   32'(wb_bus.wb_sel_o), 32'd0);
        check_eq("rst_adr",   32'(wb_bus.wb_adr_o), 32'd0);
        check_eq("rst_dat",   32'(wb_bus.wb_dat_o), 32'd0);
        check_eq("rst_rspv",  32'(rsp_valid),       32'd0);
        check_eq("rst_rspd",  32'(rsp_dat),         32'd0);
        check_eq("rst_rspe",  32'(rsp_err),         32'd0);
        check_eq("rst_busy",  32'(busy_o),          32'd0);
        wb_rst_i = 1'b0;
        step();
        check_eq("rst_cmdrdy", 32'(cmd_ready), 32'd1);

        // 1: write, zero-wait slave
        ack_en = 1'b1; ack_wait = 0; slave_rdata = 8'hA5;
        run_txn(1'b1, 3'd3, 8'h83);
        check_eq("t1_stb_cycles", 32'(stb_cycles), 32'd1);
        check_eq("t1_hold",       32'(hold_bad),   32'd0);
        check_eq("t1_rsp_dat",    32'(rsp_dat),    32'h00);
        check_eq("t1_rsp_err",    32'(rsp_err),    32'd0);
        check_eq("t1_cmdrdy_resp", 32'(cmd_ready), 32'd0);
        step();

        // 2: read with 3 wait states
        ack_wait = 3; slave_rdata = 8'h60;
        run_txn(1'b0, 3'd5, 8'h00);
        check_eq("t2_stb_cycles", 32'(stb_cycles), 32'd4);
        check_eq("t2_hold",       32'(hold_bad),   32'd0);
        check_eq("t2_rsp_dat",    32'(rsp_dat),    32'h60);
        check_eq("t2_rsp_err",    32'(rsp_err),    32'd0);
        step();

        // 3: slave never acks -> timeout after 8 cycles
        ack_en = 1'b0;
        run_txn(1'b0, 3'd2, 8'h00);
        check_eq("t3_stb_cycles", 32'(stb_cycles), 32'd8);
        check_eq("t3_rsp_err",    32'(rsp_err),    32'd1);
        check_eq("t3_rsp_dat",    32'(rsp_dat),    32'h00);
        step();
        ack_en = 1'b1; ack_wait = 0; slave_rdata = 8'h5A;
        run_txn(1'b0, 3'd1, 8'h00);
        check_eq("t3_next_err",   32'(rsp_err),    32'd0);
        check_eq("t3_next_dat",   32'(rsp_dat),    32'h5A);
        step();

        // 4: response back-pressure for 10 cycles
        rsp_ready = 1'b0; ack_wait = 1; slave_rdata = 8'hC3;
        run_txn(1'b0, 3'd6, 8'h00);
        check_eq("t4_stb_cycles", 32'(stb_cycles), 32'd2);
        check_eq("t4_rsp_dat",    32'(rsp_dat),    32'hC3);
        slave_rdata = 8'h00;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 3'd7; cmd_dat = 8'hEE;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_dat !== 8'hC3 || cmd_ready !== 1'b0 ||
                wb_bus.wb_stb_o !== 1'b0 || wb_bus.wb_cyc_o !== 1'b0)
                hold_bad++;
            step();
        end
        check_eq("t4_hold", 32'(hold_bad), 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check_eq("t4_rspv_drop", 32'(rsp_valid), 32'd0);
        check_eq("t4_cmdrdy",    32'(cmd_ready), 32'd1);
        // back-to-back commands: exactly one idle cycle between them
        ack_wait = 0;
        run_txn(1'b1, 3'd4, 8'h11);
        check_eq("t4_b2b_resp_rdy", 32'(cmd_ready), 32'd0);
        step();
        check_eq("t4_b2b_idle_busy", 32'(busy_o),    32'd0);
        check_eq("t4_b2b_idle_rdy",  32'(cmd_ready), 32'd1);
        run_txn(1'b1, 3'd4, 8'h22);
        check_eq("t4_b2b_stb_cycles", 32'(stb_cycles), 32'd1);
        check_eq("t4_b2b_hold",       32'(hold_bad),   32'd0);
        step();

        // 5: reset in the middle of a bus cycle
        ack_en = 1'b0;
        issue(1'b0, 3'd2, 8'h00);
        step();
        check_eq("t5_stb_before", 32'(wb_bus.wb_stb_o), 32'd1);
        wb_rst_i = 1'b1;
        step();
        check_eq("t5_cyc",  32'(wb_bus.wb_cyc_o), 32'd0);
        check_eq("t5_stb",  32'(wb_bus.wb_stb_o), 32'd0);
        check_eq("t5_rspv", 32'(rsp_valid),       32'd0);
        wb_rst_i = 1'b0;
        step();
        check_eq("t5_cmdrdy", 32'(cmd_ready), 32'd1);
        // spurious ack while idle
        force_ack = 1'b1;
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid !== 1'b0 || busy_o !== 1'b0) hold_bad++;
        end
        force_ack = 1'b0;
        check_eq("t5_spurious_ack", 32'(hold_bad), 32'd0);

        // 6: ack on the exact timeout cycle wins
        ack_en = 1'b1; ack_wait = 7; slave_rdata = 8'h9E;
        run_txn(1'b0, 3'd0, 8'h00);
        check_eq("t6_stb_cycles", 32'(stb_cycles), 32'd8);
        check_eq("t6_rsp_err",    32'(rsp_err),    32'd0);
        check_eq("t6_rsp_dat",    32'(rsp_dat),    32'h9E);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
